// File: rtl/lut_pkg.sv
// lut_pkg
// Shared definitions for the loadable lookup table: the controller state
// encoding and the default parameter values used by the top and its
// read-channel sub-module.
package lut_pkg;

    // Controller states: zero-filling the table, or accepting load words.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        LOAD  = 1'b1
    } lut_state_e;

    localparam int LUT_DATA_W_DEF   = 8;
    localparam int LUT_ADDR_W_DEF   = 8;
    localparam int LUT_RD_PORTS_DEF = 2;

endpackage

// File: rtl/lut_read_port.sv
// lut_read_port
// One registered read channel of the lookup table. The word selected from
// the memory array is captured on the rising clock edge; while zero_force is
// high the captured value is zero instead.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset, clears the output register
//   zero_force in   capture zero instead of mem_word this cycle
//   mem_word   in   DATA_W word read combinationally from the array
//   rd_data    out  DATA_W registered read data
module lut_read_port
    import lut_pkg::*;
#(
    parameter int DATA_W = LUT_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              zero_force,
    input  logic [DATA_W-1:0] mem_word,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Select the value to capture: forced zero or the addressed word.
    always_comb begin
        rd_data_d = {DATA_W{1'b0}};
        if (zero_force) begin
            rd_data_d = {DATA_W{1'b0}};
        end else begin
            rd_data_d = mem_word;
        end
    end

    // Output register for this read channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/loadable_lut.sv
// loadable_lut
// Lookup table of DEPTH = 2**ADDR_W words that is zero-filled after reset
// (or on request) and then loaded sequentially through a valid/ready stream.
// Several independent registered read channels access the table.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset (restarts zero-fill)
//   wr_valid    in   load word offered
//   wr_ready    out  load word accepted when wr_valid is also high
//   wr_data     in   DATA_W load word
//   load_start  in   rewind load pointer to 0, contents kept
//   clear_req   in   request zero-fill of the whole table
//   wrap_en     in   1: pointer wraps and overwrites; 0: stop when full
//   rd_addr     in   RD_PORTS*ADDR_W packed read addresses
//   rd_data     out  RD_PORTS*DATA_W packed registered read data
//   busy        out  zero-fill in progress
//   full        out  table full and wrapping disabled
//   load_count  out  ADDR_W+1 words accepted since rewind/clear, saturating
module loadable_lut
    import lut_pkg::*;
#(
    parameter int DATA_W   = LUT_DATA_W_DEF,
    parameter int ADDR_W   = LUT_ADDR_W_DEF,
    parameter int RD_PORTS = LUT_RD_PORTS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         load_start,
    input  logic                         clear_req,
    input  logic                         wrap_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic                         busy,
    output logic                         full,
    output logic [ADDR_W:0]              load_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    lut_state_e        state_d,    state_q;
    logic [ADDR_W-1:0] clr_addr_d, clr_addr_q;
    logic [ADDR_W-1:0] ptr_d,      ptr_q;
    logic [ADDR_W:0]   count_d,    count_q;

    logic              full_s;
    logic              wr_ready_s;
    logic              accept_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              force_zero_s;

    // Next-state logic, single memory write port selection and handshake.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        full_s     = 1'b0;
        wr_ready_s = 1'b0;
        accept_s   = 1'b0;
        we_s       = 1'b0;
        waddr_s    = ptr_q;
        wdata_s    = wr_data;
        case (state_q)
            CLEAR: begin
                // One zero word per cycle; load inputs are ignored here.
                we_s    = 1'b1;
                waddr_s = clr_addr_q;
                wdata_s = {DATA_W{1'b0}};
                if (clr_addr_q == ADDR_MAX) begin
                    state_d    = LOAD;
                    clr_addr_d = {ADDR_W{1'b0}};
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_ONE;
                end
            end
            LOAD: begin
                full_s     = (count_q == COUNT_MAX) && !wrap_en;
                wr_ready_s = !full_s && !load_start && !clear_req;
                accept_s   = wr_valid && wr_ready_s;
                if (clear_req) begin
                    // clear_req wins over load_start.
                    state_d    = CLEAR;
                    clr_addr_d = {ADDR_W{1'b0}};
                    ptr_d      = {ADDR_W{1'b0}};
                    count_d    = {(ADDR_W + 1){1'b0}};
                end else if (load_start) begin
                    ptr_d   = {ADDR_W{1'b0}};
                    count_d = {(ADDR_W + 1){1'b0}};
                end else if (accept_s) begin
                    we_s    = 1'b1;
                    waddr_s = ptr_q;
                    // Pointer width makes the increment wrap modulo DEPTH.
                    ptr_d   = ptr_q + ADDR_ONE;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = CLEAR;
                clr_addr_d = {ADDR_W{1'b0}};
                ptr_d      = {ADDR_W{1'b0}};
                count_d    = {(ADDR_W + 1){1'b0}};
            end
        endcase
        // Zero the read registers for the whole fill, including the edge that
        // enters it and the edge that finishes the last clear write (the array
        // is not yet fully zero when that edge samples it).
        force_zero_s = (state_q == CLEAR) || (state_d == CLEAR);
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= {ADDR_W{1'b0}};
            ptr_q      <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W + 1){1'b0}};
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
        end
    end

    // Table storage: single write port, no reset (cleared by the controller).
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    // Independent registered read channels.
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        lut_read_port #(
            .DATA_W (DATA_W)
        ) u_rd (
            .clk        (clk),
            .rst        (rst),
            .zero_force (force_zero_s),
            .mem_word   (mem_q[rd_addr[k*ADDR_W +: ADDR_W]]),
            .rd_data    (rd_data[k*DATA_W +: DATA_W])
        );
    end

    assign busy       = (state_q == CLEAR);
    assign full       = full_s;
    assign wr_ready   = wr_ready_s;
    assign load_count = count_q;

endmodule

// File: tb/tb_loadable_lut.sv
// tb_loadable_lut
// Directed bench for loadable_lut with default parameters (8-bit words,
// 256 entries, two read channels). Inputs change and outputs are checked on
// the falling clock edge.
module tb_loadable_lut;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        load_start;
    logic        clear_req;
    logic        wrap_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        full;
    logic [8:0]  load_count;

    int checks;
    int errors;

    loadable_lut dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .load_start (load_start),
        .clear_req  (clear_req),
        .wrap_en    (wrap_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .full       (full),
        .load_count (load_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count falling-edge samples with busy high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        int          n;
        logic [15:0] acc;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        load_start = 1'b0;
        clear_req  = 1'b0;
        wrap_en    = 1'b0;
        rd_addr    = {8'hFE, 8'h10};
        @(negedge clk);
        tick();
        tick();
        check("reset_busy",  {31'd0, busy}, 32'd1);
        check("reset_count", {23'd0, load_count}, 32'd0);
        check("reset_rd",    {16'd0, rd_data}, 32'd0);
        check("reset_ready", {31'd0, wr_ready}, 32'd0);
        check("reset_full",  {31'd0, full}, 32'd0);

        // Release reset: zero-fill takes exactly 256 cycles.
        rst = 1'b0;
        count_busy(n);
        check("busy_cycles", n, 32'd256);
        check("post_clr_ready", {31'd0, wr_ready}, 32'd1);
        check("post_clr_count", {23'd0, load_count}, 32'd0);
        tick();
        check("post_clr_rd", {16'd0, rd_data}, 32'd0);

        // Stream 0x00..0xFF with wrapping disabled.
        for (int i = 0; i < 256; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        check("stream_count", {23'd0, load_count}, 32'd256);
        check("stream_full",  {31'd0, full}, 32'd1);
        check("stream_ready", {31'd0, wr_ready}, 32'd0);
        // A word offered while full must not be written.
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        wr_valid = 1'b0;
        check("full_count", {23'd0, load_count}, 32'd256);
        tick();
        check("stream_rd", {16'd0, rd_data}, 32'h0000FE10);

        // Enable wrapping: write lands at address 0.
        wrap_en = 1'b1;
        #1;
        check("wrap_full",  {31'd0, full}, 32'd0);
        check("wrap_ready", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        tick();
        wr_valid = 1'b0;
        check("wrap_count", {23'd0, load_count}, 32'd256);
        check("wrap_full2", {31'd0, full}, 32'd0);
        rd_addr = {8'h01, 8'h00};
        tick();
        check("wrap_rd", {16'd0, rd_data}, 32'h000001AA);

        // Rewind, five writes, then rewind with a word offered.
        wrap_en    = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("rewind_count", {23'd0, load_count}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h11 + i);
            tick();
        end
        check("five_count", {23'd0, load_count}, 32'd5);
        wr_data    = 8'h99;
        load_start = 1'b1;
        #1;
        check("ls_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        load_start = 1'b0;
        check("ls_count", {23'd0, load_count}, 32'd0);
        wr_data = 8'h66;
        tick();
        wr_valid = 1'b0;
        rd_addr  = {8'h04, 8'h00};
        tick();
        check("ls_rd", {16'd0, rd_data}, 32'h00001566);
        rd_addr = {8'h05, 8'h05};
        tick();
        check("dup_rd", {16'd0, rd_data}, 32'h00000505);

        // Same-cycle read/write of address 3 returns the old word first.
        wr_valid = 1'b1;
        wr_data  = 8'h21;
        tick();
        wr_data  = 8'h22;
        tick();
        wr_data  = 8'h55;
        rd_addr  = {8'h00, 8'h03};
        tick();
        wr_valid = 1'b0;
        check("rw_old", {24'd0, rd_data[7:0]}, 32'h14);
        tick();
        check("rw_new", {24'd0, rd_data[7:0]}, 32'h55);
        check("rw_count", {23'd0, load_count}, 32'd4);

        // clear_req mid-load, then reset after 100 clear cycles.
        wr_valid  = 1'b1;
        wr_data   = 8'hC3;
        clear_req = 1'b1;
        #1;
        check("clr_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        check("clr_busy",  {31'd0, busy}, 32'd1);
        check("clr_count", {23'd0, load_count}, 32'd0);
        check("clr_rd",    {16'd0, rd_data}, 32'd0);
        for (int i = 0; i < 99; i++) begin
            tick();
        end
        check("clr_busy100", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        count_busy(n);
        check("rst_busy_cycles", n, 32'd256);
        acc = 16'h0000;
        for (int a = 0; a < 128; a++) begin
            rd_addr = {8'(2 * a + 1), 8'(2 * a)};
            tick();
            acc = acc | rd_data;
        end
        check("all_zero", {16'd0, acc}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/loadable_lut.md
LOADABLE_LUT -- requirements
Module: loadable_lut

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (1..32).
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_PORTS, default 2, number of independent read channels (1..4).
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_valid  in  1  load word offered.
REQ-007 SHALL have port wr_ready  out  1  load word accepted this cycle when wr_valid also high.
REQ-008 SHALL have port wr_data  in  DATA_W  load word.
REQ-009 SHALL have port load_start  in  1  rewind load pointer to 0, contents kept.
REQ-010 SHALL have port clear_req  in  1  request zero-fill of whole table.
REQ-011 SHALL have port wrap_en  in  1  1: pointer wraps and loading continues past DEPTH; 0: stop when full.
REQ-012 SHALL have port rd_addr  in  RD_PORTS*ADDR_W  packed read addresses, channel k in bits [k*ADDR_W +: ADDR_W].
REQ-013 SHALL have port rd_data  out  RD_PORTS*DATA_W  packed read data, same packing.
REQ-014 SHALL have port busy  out  1  high while zero-fill in progress.
REQ-015 SHALL have port full  out  1  high when count==DEPTH and wrap_en==0.
REQ-016 SHALL have port load_count  out  ADDR_W+1  words accepted since last rewind/clear, saturating at DEPTH.

Function
REQ-017 SHALL implement FSM with states CLEAR and LOAD only.
REQ-018 In CLEAR: one word per cycle written to zero at clr_addr, addresses 0..DEPTH-1 ascending; exactly DEPTH cycles; then go to LOAD.
REQ-019 In CLEAR: busy=1, wr_ready=0, full=0; load_start, wr_valid ignored; clear_req ignored (no restart).
REQ-020 In LOAD: busy=0; wr_ready = !full && !load_start && !clear_req (combinational).
REQ-021 Accepted write (wr_valid && wr_ready): mem[ptr] <= wr_data; ptr <= ptr+1 modulo DEPTH; load_count <= min(load_count+1, DEPTH).
REQ-022 With wrap_en=1, ptr wraps DEPTH-1 -> 0 and overwrites oldest data; load_count stays DEPTH.
REQ-023 With wrap_en=0 and load_count==DEPTH, full=1, wr_ready=0, no write; raising wrap_en then resumes at ptr=0.
REQ-024 load_start in LOAD: next cycle ptr=0, load_count=0; memory unchanged; same-cycle write dropped (wr_ready low).
REQ-025 clear_req in LOAD: next cycle state=CLEAR, ptr=0, load_count=0, clr_addr=0; clear_req has priority over load_start.
REQ-026 Reads: each channel registered, 1-cycle latency: rd_data[k] at edge n+1 = mem[rd_addr[k]] sampled at edge n.
REQ-027 Read and write same address same cycle: read returns pre-write (old) data.
REQ-028 While busy=1, every rd_data channel SHALL read 0 (registered output forced to zero).
REQ-029 All read channels SHALL be independent; identical addresses on several channels give identical data.

Reset
REQ-030 On rst: state=CLEAR, clr_addr=0, ptr=0, load_count=0, rd_data all 0; busy=1 from reset deassertion until zero-fill completes.
REQ-031 rst mid-load or mid-clear SHALL abort and restart zero-fill from address 0; memory array itself is not reset, only cleared by the FSM.

Structure
REQ-032 Shared package lut_pkg SHALL hold the state enum (CLEAR, LOAD) and default parameter constants.
REQ-033 One sub-module lut_read_port (one registered read channel with zero-force) SHALL be instantiated RD_PORTS times via generate.
REQ-034 Memory SHALL be a single DATA_W x DEPTH array with one write port, inferable as register file.

Verification
REQ-035 Reset, defaults: release rst -> busy=1 for exactly 256 cycles, then busy=0, wr_ready=1, load_count=0; any read returns 0x00.
REQ-036 Stream 0x00..0xFF, wrap_en=0 -> load_count=256, full=1, wr_ready=0; rd_addr ch0=0x10, ch1=0xFE -> next cycle rd_data 0x10, 0xFE.
REQ-037 Full table, wrap_en=1, write 0xAA -> stored at address 0, load_count stays 256, full=0.
REQ-038 After 5 writes assert load_start with wr_valid=1 -> that word dropped, load_count=0, next write lands at address 0, address 4 keeps old data.
REQ-039 Read address 3 while writing 0x55 to address 3 -> rd_data old value that cycle, 0x55 on following read.
REQ-040 clear_req mid-load, then rst asserted after 100 clear cycles -> busy high again for full 256 cycles; all addresses read 0x00 afterwards.
